// File: rtl/conv1d_pkg.sv
// Shared Conv1D definitions: scheduler state encoding, L0 status codes,
// the scheduler's registered output bundle and a counter-width helper
// used by the Conv1D blocks.
package conv1d_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LD_W,
    ST_LD_IN,
    ST_LD_OUT,
    ST_L0_FILL,
    ST_COMPUTE,
    ST_L0_WB,
    ST_WR_OUT,
    ST_DONE
  } sched_state_t;

  localparam logic [1:0] L0_ST_IDLE   = 2'b00;
  localparam logic [1:0] L0_ST_ACTIVE = 2'b01;

  // Every scheduler output except tile_idx, grouped so that the whole set
  // can be decoded in one place and registered in one flop bank.
  typedef struct packed {
    logic       busy;
    logic       done;
    logic       mem_w_rst;
    logic       mem_i_rst;
    logic       mem_o_rst;
    logic       l0_w_rst;
    logic       l0_i_rst;
    logic       l0_o_rst;
    logic [1:0] l0_w_st;
    logic [1:0] l0_i_st;
    logic [1:0] l0_o_st;
    logic       l0_ready;
    logic       w_load;
    logic       i_load;
    logic       o_load;
    logic       o_write;
  } sched_out_t;

  // Bits needed to hold any value in 0..max_value (never less than one).
  function automatic int count_width(input int max_value);
    return (max_value < 1) ? 1 : $clog2(max_value + 1);
  endfunction

  // Larger of two integers, used to size shared counters.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Output pattern while parked: every index held in reset, nothing active.
  function automatic sched_out_t idle_outputs();
    sched_out_t o;
    o           = '0;
    o.mem_w_rst = 1'b1;
    o.mem_i_rst = 1'b1;
    o.mem_o_rst = 1'b1;
    o.l0_w_rst  = 1'b1;
    o.l0_i_rst  = 1'b1;
    o.l0_o_rst  = 1'b1;
    return o;
  endfunction

endpackage

// File: rtl/conv1d_access_scheduler.sv
// Conv1D job sequencer: walks Mem_Access_Index_Setting through file load,
// tiled L0 fill / compute / writeback and output dump, with a start/done
// handshake. Optional output preload phase (LD_OUT) is enabled by defining
// CONV1D_OUT_PRELOAD_EN; without it LD_IN goes straight to L0_FILL.
// All outputs are registered decodes of the next (state, cnt, tile) so they
// line up with the state they describe.
module conv1d_access_scheduler
  import conv1d_pkg::*;
#(
  parameter int Weight_Nums    = 4,
  parameter int Input_Nums     = 11,
  parameter int Output_Nums    = 8,
  parameter int L0_Weight_Nums = 2,
  parameter int L0_Output_Nums = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  output logic Mem_Weight_Index_Reset,
  output logic Mem_Input_Index_Reset,
  output logic Mem_Output_Index_Reset,
  output logic L0_Weight_Index_Reset,
  output logic L0_Input_Index_Reset,
  output logic L0_Output_Index_Reset,
  output logic [1:0] L0_Weight_Status,
  output logic [1:0] L0_Input_Status,
  output logic [1:0] L0_Output_Status,
  output logic L0_Data_Is_Ready,
  output logic Weight_Loading_From_File,
  output logic Input_Loading_From_File,
  output logic Output_Loading_From_File,
  output logic Output_Writing_To_File,
  output logic [$clog2(Weight_Nums/L0_Weight_Nums+1)-1:0] tile_idx
);

  localparam int NUM_TILES = Weight_Nums / L0_Weight_Nums;
  localparam int TILE_W    = $clog2(NUM_TILES + 1);
  localparam int COMPUTE_N = L0_Output_Nums * L0_Weight_Nums;
  localparam int MAX_N     = max_int(max_int(Weight_Nums, Input_Nums),
                                     max_int(Output_Nums, COMPUTE_N));
  localparam int CNT_W     = count_width(MAX_N);

  localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(NUM_TILES - 1);

  sched_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TILE_W-1:0] tile_q, tile_d;
  sched_out_t        out_q, out_d;
  logic              phase_last;
  logic              entry_d;

  // Final cycle index N of each working phase; a phase spans cnt 0..N.
  function automatic logic [CNT_W-1:0] phase_len(input sched_state_t s);
    case (s)
      ST_LD_W:    return CNT_W'(Weight_Nums);
      ST_LD_IN:   return CNT_W'(Input_Nums);
      ST_LD_OUT:  return CNT_W'(Output_Nums);
      ST_L0_FILL: return CNT_W'(L0_Weight_Nums);
      ST_COMPUTE: return CNT_W'(COMPUTE_N);
      ST_L0_WB:   return CNT_W'(L0_Output_Nums);
      ST_WR_OUT:  return CNT_W'(Output_Nums);
      default:    return '0;
    endcase
  endfunction

  assign phase_last = (cnt_q == phase_len(state_q));
  assign entry_d    = (cnt_d == '0);

  // Next state, phase counter and tile counter; abort overrides every
  // transition once a job is running, and IDLE always parks the counters.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    tile_d  = tile_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LD_W;
      end
      ST_LD_W: begin
        if (phase_last) state_d = ST_LD_IN;
      end
      ST_LD_IN: begin
        if (phase_last) begin
`ifdef CONV1D_OUT_PRELOAD_EN
          state_d = ST_LD_OUT;
`else
          state_d = ST_L0_FILL;
`endif
        end
      end
`ifdef CONV1D_OUT_PRELOAD_EN
      ST_LD_OUT: begin
        if (phase_last) state_d = ST_L0_FILL;
      end
`endif
      ST_L0_FILL: begin
        if (phase_last) state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        if (phase_last) state_d = ST_L0_WB;
      end
      ST_L0_WB: begin
        if (phase_last) begin
          if (tile_q < LAST_TILE) begin
            tile_d  = tile_q + 1'b1;
            state_d = ST_L0_FILL;
          end else begin
            state_d = ST_WR_OUT;
          end
        end
      end
      ST_WR_OUT: begin
        if (phase_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if ((state_q != ST_IDLE) && abort) state_d = ST_IDLE;
    if (state_d != state_q) cnt_d = '0;
    if (state_d == ST_IDLE) begin
      cnt_d  = '0;
      tile_d = '0;
    end
  end

  // Moore decode of the upcoming (state, cnt, tile): entry cycle pulses the
  // phase's index resets, the remaining cycles raise its flag or status.
  always_comb begin
    out_d = '0;
    case (state_d)
      ST_IDLE: begin
        out_d = idle_outputs();
      end
      ST_LD_W: begin
        out_d.mem_w_rst = entry_d;
        out_d.w_load    = !entry_d;
      end
      ST_LD_IN: begin
        out_d.mem_i_rst = entry_d;
        out_d.i_load    = !entry_d;
      end
`ifdef CONV1D_OUT_PRELOAD_EN
      ST_LD_OUT: begin
        out_d.mem_o_rst = entry_d;
        out_d.o_load    = !entry_d;
      end
`endif
      ST_L0_FILL: begin
        if (entry_d && (tile_d == '0)) begin
          out_d.mem_w_rst = 1'b1;
          out_d.mem_i_rst = 1'b1;
          out_d.mem_o_rst = 1'b1;
        end
        out_d.l0_w_st = entry_d ? L0_ST_IDLE : L0_ST_ACTIVE;
        out_d.l0_i_st = entry_d ? L0_ST_IDLE : L0_ST_ACTIVE;
      end
      ST_COMPUTE: begin
        out_d.l0_w_rst = entry_d;
        out_d.l0_i_rst = entry_d;
        out_d.l0_o_rst = entry_d;
        out_d.l0_ready = !entry_d;
      end
      ST_L0_WB: begin
        out_d.l0_o_st = entry_d ? L0_ST_IDLE : L0_ST_ACTIVE;
      end
      ST_WR_OUT: begin
        out_d.mem_o_rst = entry_d;
        out_d.o_write   = !entry_d;
      end
      ST_DONE: begin
        out_d.done = 1'b1;
      end
      default: begin
        out_d = idle_outputs();
      end
    endcase
    out_d.busy = (state_d != ST_IDLE);
  end

  // State, counters and the registered output bank; reset parks in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tile_q  <= '0;
      out_q   <= idle_outputs();
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tile_q  <= tile_d;
      out_q   <= out_d;
    end
  end

  assign busy                     = out_q.busy;
  assign done                     = out_q.done;
  assign Mem_Weight_Index_Reset   = out_q.mem_w_rst;
  assign Mem_Input_Index_Reset    = out_q.mem_i_rst;
  assign Mem_Output_Index_Reset   = out_q.mem_o_rst;
  assign L0_Weight_Index_Reset    = out_q.l0_w_rst;
  assign L0_Input_Index_Reset     = out_q.l0_i_rst;
  assign L0_Output_Index_Reset    = out_q.l0_o_rst;
  assign L0_Weight_Status         = out_q.l0_w_st;
  assign L0_Input_Status          = out_q.l0_i_st;
  assign L0_Output_Status         = out_q.l0_o_st;
  assign L0_Data_Is_Ready         = out_q.l0_ready;
  assign Weight_Loading_From_File = out_q.w_load;
  assign Input_Loading_From_File  = out_q.i_load;
  assign Output_Loading_From_File = out_q.o_load;
  assign Output_Writing_To_File   = out_q.o_write;
  assign tile_idx                 = tile_q;

endmodule
